// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_seq_ctrl
// Description : Sequences one K-beat accumulation job over an N_MACS-wide
//               MAC array: clear, skewed operand feed, skew drain, done.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_seq_ctrl #(
    parameter int N_MACS = 4,
    parameter int K_MAX  = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  k_len,
    input  logic              hold,
    output logic [N_MACS-1:0] valid_ctrl,
    output logic [N_MACS-1:0] clear,
    output logic              feed_en,
    output logic [CNT_W-1:0]  feed_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int DRAIN_W = (N_MACS > 2) ? $clog2(N_MACS - 1) : 1;
    localparam logic [CNT_W-1:0]   c_k_max      = CNT_W'(K_MAX);
    localparam logic [DRAIN_W-1:0] c_drain_last = DRAIN_W'((N_MACS > 1) ? (N_MACS - 2) : 0);

    state_t             r_state;
    logic [CNT_W-1:0]   r_k;
    logic [CNT_W-1:0]   r_idx;
    logic [DRAIN_W-1:0] r_drain;

    logic [CNT_W-1:0]   w_k_sat;
    logic               w_held;
    logic               w_feed_en;
    logic [N_MACS-1:0]  w_valid_raw;

    assign w_k_sat   = (k_len > c_k_max) ? c_k_max : k_len;
    assign w_held    = hold && ((r_state == S_FEED) || (r_state == S_DRAIN));
    assign w_feed_en = (r_state == S_FEED) && !hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_idx   <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_k     <= w_k_sat;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_idx   <= '0;
                    r_drain <= '0;
                    r_state <= (r_k == '0) ? S_DONE : S_FEED;
                end
                S_FEED: begin
                    if (!hold) begin
                        // feed_idx keeps the last beat index through DRAIN
                        if (r_idx == r_k - 1'b1) begin
                            r_state <= (N_MACS > 1) ? S_DRAIN : S_DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!hold) begin
                        if (r_drain == c_drain_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_drain <= r_drain + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_idx   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    generate
        if (N_MACS > 1) begin : g_skew
            logic [N_MACS-2:0] r_skew;

            assign w_valid_raw = {r_skew, w_feed_en};

            // Column i register follows column i-1 only on non-held cycles
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_skew <= '0;
                end else if (!w_held) begin
                    r_skew <= w_valid_raw[N_MACS-2:0];
                end
            end
        end else begin : g_no_skew
            assign w_valid_raw = w_feed_en;
        end
    endgenerate

    assign valid_ctrl = w_held ? '0 : w_valid_raw;
    assign clear      = {N_MACS{r_state == S_CLEAR}};
    assign feed_en    = w_feed_en;
    assign feed_idx   = ((r_state == S_FEED) || (r_state == S_DRAIN)) ? r_idx : '0;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_seq_ctrl
// Description : Directed per-cycle vector bench for systolic_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_seq_ctrl;

    localparam int N_MACS = 4;
    localparam int K_MAX  = 16;
    localparam int CNT_W  = 5;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] k_len;
    logic             hold;
    logic [3:0]       valid_ctrl;
    logic [3:0]       clear;
    logic             feed_en;
    logic [CNT_W-1:0] feed_idx;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    systolic_seq_ctrl #(
        .N_MACS (N_MACS),
        .K_MAX  (K_MAX),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .k_len      (k_len),
        .hold       (hold),
        .valid_ctrl (valid_ctrl),
        .clear      (clear),
        .feed_en    (feed_en),
        .feed_idx   (feed_idx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column-0 MAC with weight 2, fed a_beats[feed_idx]
    logic [15:0] acc0;
    logic [7:0]  a_beats [0:2];
    always @(posedge clk) begin
        if (clear[0]) acc0 <= '0;
        else if (valid_ctrl[0] && feed_idx < 3) acc0 <= acc0 + 16'(a_beats[feed_idx]) * 16'd2;
    end

    typedef struct {
        logic             start;
        logic [CNT_W-1:0] k_len;
        logic             hold;
        logic [3:0]       valid;
        logic [3:0]       clr;
        logic             feed;
        logic [CNT_W-1:0] idx;
        logic             chk_idx;
        logic             busy;
        logic             done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic s, logic [CNT_W-1:0] k, logic h, logic [3:0] vl,
                               logic [3:0] c, logic f, logic [CNT_W-1:0] ix,
                               logic ci, logic b, logic d);
        vec_t r;
        r.start = s; r.k_len = k; r.hold = h; r.valid = vl; r.clr = c;
        r.feed = f; r.idx = ix; r.chk_idx = ci; r.busy = b; r.done = d;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_rows(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            start = vecs[i].start;
            k_len = vecs[i].k_len;
            hold  = vecs[i].hold;
            @(negedge clk);
            check($sformatf("%s row %0d {valid,clear,feed,idx,busy,done}", tag, i),
                  {valid_ctrl, clear, 3'b0, feed_en, 3'b0, (vecs[i].chk_idx ? feed_idx : 5'd0),
                   3'b0, busy, 3'b0, done},
                  {vecs[i].valid, vecs[i].clr, 3'b0, vecs[i].feed, 3'b0,
                   (vecs[i].chk_idx ? vecs[i].idx : 5'd0), 3'b0, vecs[i].busy, 3'b0, vecs[i].done});
            step();
        end
    endtask

    task automatic mac_job(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                           input logic [15:0] exp_acc);
        int cyc;
        bit seen;
        a_beats[0] = a0; a_beats[1] = a1; a_beats[2] = a2;
        start = 1'b1; k_len = 5'd3;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (cyc = 1; cyc < 30 && !seen; cyc++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check("mac done cycle", 32'(cyc), 32'd8);
                check("mac acc_out_0 at done", 32'(acc0), 32'(exp_acc));
            end
            step();
        end
        if (!seen) check("mac done timeout", 32'd0, 32'd1);
        step();
    endtask

    initial begin
        int feeds, max_idx, cyc;
        bit seen;

        // basic job K=3 (rows 0..9)
        vecs.push_back(v(1,3,0, 4'h0,4'h0,0,0,1,0,0));
        vecs.push_back(v(0,3,0, 4'h0,4'hF,0,0,1,1,0));
        vecs.push_back(v(0,3,0, 4'h1,4'h0,1,0,1,1,0));
        vecs.push_back(v(0,3,0, 4'h3,4'h0,1,1,1,1,0));
        vecs.push_back(v(0,3,0, 4'h7,4'h0,1,2,1,1,0));
        vecs.push_back(v(0,3,0, 4'hE,4'h0,0,0,0,1,0));
        vecs.push_back(v(0,3,0, 4'hC,4'h0,0,0,0,1,0));
        vecs.push_back(v(0,3,0, 4'h8,4'h0,0,0,0,1,0));
        vecs.push_back(v(0,3,0, 4'h0,4'h0,0,0,1,1,1));
        vecs.push_back(v(0,3,0, 4'h0,4'h0,0,0,1,0,0));
        // hold mid-FEED for 2 cycles after beat 1 (rows 10..21)
        vecs.push_back(v(1,3,0, 4'h0,4'h0,0,0,1,0,0));
        vecs.push_back(v(0,3,0, 4'h0,4'hF,0,0,1,1,0));
        vecs.push_back(v(0,3,0, 4'h1,4'h0,1,0,1,1,0));
        vecs.push_back(v(0,3,0, 4'h3,4'h0,1,1,1,1,0));
        vecs.push_back(v(0,3,1, 4'h0,4'h0,0,2,1,1,0));
        vecs.push_back(v(0,3,1, 4'h0,4'h0,0,2,1,1,0));
        vecs.push_back(v(0,3,0, 4'h7,4'h0,1,2,1,1,0));
        vecs.push_back(v(0,3,0, 4'hE,4'h0,0,0,0,1,0));
        vecs.push_back(v(0,3,0, 4'hC,4'h0,0,0,0,1,0));
        vecs.push_back(v(0,3,0, 4'h8,4'h0,0,0,0,1,0));
        vecs.push_back(v(0,3,0, 4'h0,4'h0,0,0,1,1,1));
        vecs.push_back(v(0,3,0, 4'h0,4'h0,0,0,1,0,0));
        // k_len=0, hold ignored in CLEAR/DONE (rows 22..25)
        vecs.push_back(v(1,0,0, 4'h0,4'h0,0,0,1,0,0));
        vecs.push_back(v(0,0,1, 4'h0,4'hF,0,0,1,1,0));
        vecs.push_back(v(0,0,1, 4'h0,4'h0,0,0,1,1,1));
        vecs.push_back(v(0,0,0, 4'h0,4'h0,0,0,1,0,0));
        // start held through a K=2 job, k_len changed mid-job, then K=1 (rows 26..41)
        vecs.push_back(v(1,2,0, 4'h0,4'h0,0,0,1,0,0));
        vecs.push_back(v(1,9,0, 4'h0,4'hF,0,0,1,1,0));
        vecs.push_back(v(1,9,0, 4'h1,4'h0,1,0,1,1,0));
        vecs.push_back(v(1,9,0, 4'h3,4'h0,1,1,1,1,0));
        vecs.push_back(v(1,9,0, 4'h6,4'h0,0,0,0,1,0));
        vecs.push_back(v(1,9,0, 4'hC,4'h0,0,0,0,1,0));
        vecs.push_back(v(1,9,0, 4'h8,4'h0,0,0,0,1,0));
        vecs.push_back(v(1,9,0, 4'h0,4'h0,0,0,1,1,1));
        vecs.push_back(v(1,1,0, 4'h0,4'h0,0,0,1,0,0));
        vecs.push_back(v(0,1,0, 4'h0,4'hF,0,0,1,1,0));
        vecs.push_back(v(0,1,0, 4'h1,4'h0,1,0,1,1,0));
        vecs.push_back(v(0,1,0, 4'h2,4'h0,0,0,0,1,0));
        vecs.push_back(v(0,1,0, 4'h4,4'h0,0,0,0,1,0));
        vecs.push_back(v(0,1,0, 4'h8,4'h0,0,0,0,1,0));
        vecs.push_back(v(0,1,0, 4'h0,4'h0,0,0,1,1,1));
        vecs.push_back(v(0,1,0, 4'h0,4'h0,0,0,1,0,0));

        a_beats[0] = '0; a_beats[1] = '0; a_beats[2] = '0;
        rst = 1'b1; start = 1'b0; k_len = '0; hold = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("outputs during reset", {valid_ctrl, clear, feed_en, feed_idx, busy, done}, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle cycle %0d outputs", i),
                  {valid_ctrl, clear, feed_en, feed_idx, busy, done}, 32'd0);
            step();
        end

        run_rows(0, vecs.size() - 1, "table");

        // k_len=31 saturates to K_MAX beats
        start = 1'b1; k_len = 5'd31;
        step();
        start = 1'b0;
        feeds = 0; max_idx = 0; seen = 1'b0;
        for (cyc = 1; cyc < 60 && !seen; cyc++) begin
            @(negedge clk);
            if (feed_en) begin
                feeds++;
                if (int'(feed_idx) > max_idx) max_idx = int'(feed_idx);
            end
            if (done) begin
                seen = 1'b1;
                check("sat done cycle", 32'(cyc), 32'(K_MAX + N_MACS + 1));
            end
            step();
        end
        if (!seen) check("sat done timeout", 32'd0, 32'd1);
        check("sat feed beats", 32'(feeds), 32'(K_MAX));
        check("sat last feed_idx", 32'(max_idx), 32'(K_MAX - 1));
        step();

        // reset in the middle of DRAIN aborts without done
        start = 1'b1; k_len = 5'd3;
        step();
        start = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("pre-abort in DRAIN", {valid_ctrl, busy}, {4'hE, 1'b1});
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post-abort outputs", {valid_ctrl, clear, feed_en, feed_idx, busy, done}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
            step();
        end
        check("no done/busy after abort", 32'(seen), 32'd0);
        run_rows(0, 9, "after-abort");

        // end-to-end accumulate: w=2
        mac_job(8'd10, 8'd5, 8'd1, 16'd32);
        mac_job(8'd5,  8'd5, 8'd5, 16'd30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
